// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared CPU definitions for the multiply/divide execute stage
package mul_div_unit_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } md_op_e;
  localparam int CALC_CYCLES = 32;
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide, one bit per cycle on a shared shift register
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e state, state_d;
  md_op_e op_i, op_q;
  logic [63:0] acc, step;
  logic [31:0] b, m1, m2, fast_val, quot, rem, res_d;
  logic [63:0] prod;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, fast, accept, s1s, s2s, div0, ovf;
  assign op_i = md_op_e'(op);
  assign busy = state != IDLE;
  always_comb begin
    accept   = state == IDLE && start && !flush;
    s1s      = op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2s      = op_i inside {OP_MULH, OP_DIV, OP_REM};
    m1       = (s1s && src1[31]) ? -src1 : src1;
    m2       = (s2s && src2[31]) ? -src2 : src2;
    div0     = op_i[2] && src2 == 32'd0;
    ovf      = (op_i == OP_DIV || op_i == OP_REM) && src1 == 32'h8000_0000 && src2 == 32'hFFFF_FFFF;
    fast_val = div0 ? (op_i[1] ? src1 : 32'hFFFF_FFFF) : (op_i[1] ? 32'd0 : 32'h8000_0000);
    state_d  = state == IDLE ? (accept ? ((div0 || ovf) ? DONE : CALC) : IDLE)
             : flush ? IDLE
             : state == CALC ? (cnt == 5'(CALC_CYCLES - 1) ? DONE : CALC)
             : IDLE;
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : 33'd0);
    div_diff = {1'b0, acc[63:31]} - {2'b0, b};
    step     = op_q[2] ? (div_diff[33] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1})
             : {mul_sum, acc[31:1]};
    prod     = neg_q ? -acc : acc;
    quot     = neg_q ? -acc[31:0] : acc[31:0];
    rem      = neg_r ? -acc[63:32] : acc[63:32];
    res_d    = fast ? acc[31:0]
             : !op_q[2] ? (op_q == OP_MUL ? prod[31:0] : prod[63:32])
             : op_q[1] ? rem : quot;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_MUL;
      acc    <= '0;
      b      <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      fast   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= state == DONE && !flush;
      if (state == DONE && !flush) result <= res_d;
      if (accept) begin
        op_q  <= op_i;
        cnt   <= '0;
        fast  <= div0 || ovf;
        neg_q <= (s1s && src1[31]) ^ (s2s && src2[31]);
        neg_r <= s1s && src1[31];
        b     <= op_i[2] ? m2 : m1;
        acc   <= {32'd0, (div0 || ovf) ? fast_val : (op_i[2] ? m1 : m2)};
      end else if (state == CALC && !flush) begin
        acc <= step;
        cnt <= cnt + 5'd1;
      end
    end
  end
endmodule
